// File: rtl/shift_right_seq.sv
// shift_right_seq: lane-granular right shifter for words of LANES lanes of
// LANE_W bits each. Data moves toward lane 0, vacated upper lanes take the
// fill lane captured at accept. Illegal shifts (> MAX_SHIFT) return the
// input word unchanged with out_err set.
//
// Build option: define SHIFT_RIGHT_SEQ_FAST_EN to replace the iterative
// one-lane-per-cycle shifter with a single-cycle lane mux (IDLE -> DONE for
// every shift). Results and out_err are identical in both builds.
//
// Handshake: a word is accepted on a rising edge where in_valid && in_ready;
// a result is consumed on a rising edge where out_valid && out_ready.
// in_ready is high only in IDLE (and never during reset); out_valid is high
// only in DONE, where out and out_err are held stable until consumed.
// Inputs are not sampled outside the accepting edge.
module shift_right_seq #(
    parameter int LANE_W    = 12,
    parameter int LANES     = 8,
    parameter int MAX_SHIFT = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANE_W*LANES-1:0]   in,
    input  logic [2:0]                shift,
    input  logic [LANE_W-1:0]         fill,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANE_W*LANES-1:0]   out,
    output logic                      out_err,
    output logic [1:0]                state_dbg
);

    localparam int W = LANE_W * LANES;

    localparam logic [1:0] IDLE  = 2'd0;
`ifndef SHIFT_RIGHT_SEQ_FAST_EN
    localparam logic [1:0] SHIFT = 2'd1;
`endif
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] MAX_SHIFT_3 = 3'(MAX_SHIFT);

    logic [1:0]   state_q;
    logic [W-1:0] data_q;
    logic         err_q;
    logic         accept;
    logic         legal;

    assign legal  = (shift <= MAX_SHIFT_3);
    assign accept = in_valid && in_ready;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign out       = data_q;
    assign out_err   = err_q;
    assign state_dbg = state_q;

`ifdef SHIFT_RIGHT_SEQ_FAST_EN

    logic [W-1:0] fast_data;

    // Full lane mux: lane i takes input lane i+shift, or fill past the top.
    always_comb begin
        fast_data = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i + int'(shift) < LANES) begin
                fast_data[i*LANE_W +: LANE_W] = in[(i + int'(shift))*LANE_W +: LANE_W];
            end else begin
                fast_data[i*LANE_W +: LANE_W] = fill;
            end
        end
    end

    // Control: every accepted word goes straight to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE:    if (accept) state_q <= DONE;
                DONE:    if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath: capture the shifted word (or the raw word if illegal) at accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
        end else if (accept) begin
            data_q <= legal ? fast_data : in;
            err_q  <= !legal;
        end
    end

`else

    logic [2:0]        cnt_q;
    logic [LANE_W-1:0] fill_q;

    // Control: zero or illegal shifts skip SHIFT; otherwise step until the
    // last lane move (cnt == 1 going to 0) and then present the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q <= ((shift == 3'd0) || !legal) ? DONE : SHIFT;
                    end
                end
                SHIFT:   if (cnt_q == 3'd1) state_q <= DONE;
                DONE:    if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Datapath: load at accept, then move one lane toward lane 0 per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            err_q  <= 1'b0;
            cnt_q  <= 3'd0;
            fill_q <= '0;
        end else if (accept) begin
            data_q <= in;
            err_q  <= !legal;
            cnt_q  <= shift;
            fill_q <= fill;
        end else if (state_q == SHIFT) begin
            data_q <= {fill_q, data_q[W-1:LANE_W]};
            cnt_q  <= cnt_q - 3'd1;
        end
    end

`endif

endmodule

// File: tb/tb_shift_right_seq.sv
// Bench for shift_right_seq: directed vectors plus randomized transactions.
// The driver pushes expected {err, word} and expected latency at accept; a
// negedge monitor pops and compares whenever the DUT presents a result.
module tb_shift_right_seq;

    localparam int LANE_W = 12;
    localparam int LANES  = 8;
    localparam int W      = LANE_W * LANES;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_word = '0;
    logic [2:0]    shift = 3'd0;
    logic [11:0]   fill = '0;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_word;
    logic          out_err;
    logic [1:0]    state_dbg;

    logic [W:0]    exp_q[$];
    int            lat_q[$];
    int            acc_q[$];

    int            chk_cnt  = 0;
    int            pass_cnt = 0;
    int            cyc      = 0;
    int            rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

    localparam logic [W-1:0] BASE = 96'h777666555444333222111000;

    shift_right_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (in_word),
        .shift     (shift),
        .fill      (fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_word),
        .out_err   (out_err),
        .state_dbg (state_dbg)
    );

    // clock / reset-independent cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    // consumer readiness, changed just after each rising edge
    initial out_ready = 1'b1;
    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s actual=%h required=%h", name, act, exp);
    endtask

    // Reference: treat the word as a queue of lanes, drop s lanes from the
    // bottom and append s fill lanes at the top.
    function automatic logic [W:0] ref_model(input logic [W-1:0] w, input int s,
                                             input logic [11:0] f);
        logic [11:0]  lanes[$];
        logic [W-1:0] r;
        if (s > 5) return {1'b1, w};
        for (int i = 0; i < LANES; i++) lanes.push_back(w[i*LANE_W +: LANE_W]);
        for (int k = 0; k < s; k++) begin
            void'(lanes.pop_front());
            lanes.push_back(f);
        end
        r = '0;
        for (int i = 0; i < LANES; i++) r[i*LANE_W +: LANE_W] = lanes[i];
        return {1'b0, r};
    endfunction

    function automatic int exp_lat(input int s);
`ifdef SHIFT_RIGHT_SEQ_FAST_EN
        return 1;
`else
        return (s == 0 || s > 5) ? 1 : s + 1;
`endif
    endfunction

    task automatic send_exp(input logic [W-1:0] w, input logic [2:0] s,
                            input logic [11:0] f, input logic [W:0] e);
        int n;
        @(negedge clk);
        in_valid = 1'b1;
        in_word  = w;
        shift    = s;
        fill     = f;
        n = 0;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        lat_q.push_back(exp_lat(int'(s)));
        acc_q.push_back(cyc);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_word  = {$urandom, $urandom, $urandom};
        shift    = 3'($urandom);
        fill     = 12'($urandom);
    endtask

    task automatic send(input logic [W-1:0] w, input logic [2:0] s, input logic [11:0] f);
        send_exp(w, s, f, ref_model(w, int'(s), f));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    // monitor: latency, hold-while-stalled, result compare, post-transfer state
    logic         prev_valid = 1'b0;
    logic         prev_hs    = 1'b0;
    logic [W:0]   prev_out   = '0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            if (prev_hs) check("idle_after_xfer", {in_ready, out_valid}, 2'b10);
            if (out_valid) begin
                check("busy_in_ready", in_ready, 0);
                if (!prev_valid) begin
                    if (lat_q.size() == 0) check("unexpected_valid", 1, 0);
                    else check("latency", cyc - acc_q.pop_front(), lat_q.pop_front());
                end else begin
                    check("hold", {out_err, out_word}, prev_out);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) check("unexpected_result", 1, 0);
                    else check("result", {out_err, out_word}, exp_q.pop_front());
                end
            end
            prev_valid = out_valid;
            prev_out   = {out_err, out_word};
            prev_hs    = out_valid && out_ready;
        end
    end

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_out", out_word, 0);
        check("rst_out_err", out_err, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", in_ready, 1);

        // directed vectors
        send_exp(BASE, 3'd2, 12'hABC, {1'b0, 96'hABCABC777666555444333222});
        drain();
        send_exp(BASE, 3'd0, 12'hABC, {1'b0, BASE});
        send_exp(BASE, 3'd6, 12'hFFF, {1'b1, BASE});
        send_exp(BASE, 3'd7, 12'hFFF, {1'b1, BASE});
        send_exp(BASE, 3'd5, 12'hABC, {1'b0, 96'hABCABCABCABCABC777666555});
        drain();

        // backpressure with a competing request
        rdy_mode = 2;
        send_exp(BASE, 3'd1, 12'hABC, {1'b0, 96'hABC777666555444333222111});
        in_valid = 1'b1;
        in_word  = 96'hDEADBEEF;
        shift    = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_no_accept", in_ready, 0);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 50 && !out_valid; n++) @(negedge clk);
        check("bp_valid", out_valid, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_held", {out_valid, out_word}, {1'b1, 96'hABC777666555444333222111});
        end
        rdy_mode = 0;
        drain();

        // reset mid-operation
        rdy_mode = 2;
        send(BASE, 3'd5, 12'hABC);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_out", out_word, 0);
        check("abort_in_ready", in_ready, 0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(negedge clk);
        rst = 1'b0;
        rdy_mode = 0;
        @(negedge clk);
        check("ready_after_abort", in_ready, 1);
        send_exp(BASE, 3'd1, 12'hABC, {1'b0, 96'hABC777666555444333222111});
        drain();

        // randomized traffic with random consumer stalls
        rdy_mode = 1;
        for (int t = 0; t < 80; t++) begin
            send({$urandom, $urandom, $urandom}, 3'($urandom_range(0, 7)), 12'($urandom));
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        rdy_mode = 0;
        drain();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
